cmd_replay_fifo: RTL and testbench
==================================

Name: cmd_replay_fifo

Overview:
- Parametrised synchronous command FIFO with a replay window, the successor to the fixed-size command FIFO.
- Consumed commands stay resident until explicitly committed, so the command sequencer can rewind and re-issue one iteration's command stream without the producer re-writing it.
- Sits between the host command loader (producer) and the PE command sequencer (consumer).

Parameters:
- DATA_W, 64: command word width in bits.
- DEPTH, 16: number of entries; must be a power of two and at least 2.
- AFULL_TH, 2: almost_full asserts when the number of free entries is less than or equal to AFULL_TH.
- PTR_W, $clog2(DEPTH)+1: pointer width, including the wrap bit. Derived; do not override.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  command to write.
- full  out  1  no free entry.
- almost_full  out  1  free entries <= AFULL_TH.
- rd_en  in  1  read request.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  rd_data holds a valid command this cycle.
- empty  out  1  no unread entry (rd_ptr == wr_ptr).
- replay  in  1  rewind rd_ptr to base_ptr.
- commit  in  1  release consumed entries (base_ptr <= rd_ptr).
- flush  in  1  discard everything.
- occupancy  out  PTR_W  wr_ptr - base_ptr, i.e. resident entries, including read but uncommitted.

Behaviour:
- Pointers: wr_ptr, rd_ptr and base_ptr, each PTR_W bits with modulo-2^PTR_W arithmetic.
- RAM is indexed by the low $clog2(DEPTH) pointer bits.
- Invariant: base_ptr <= rd_ptr <= wr_ptr in circular order.
- full = (occupancy == DEPTH). Space is reclaimed only by commit or flush, never by a read.
- empty = (rd_ptr == wr_ptr).
- Reset (asynchronous): all pointers = 0, rd_valid = 0, rd_data = 0. Therefore full = 0, empty = 1, almost_full = 0, occupancy = 0. Reset mid-operation discards all contents.
- Write accept: wr_en && !full && !flush. RAM[wr_ptr] <= wr_data; wr_ptr increments.
- Write while full: dropped; no state change.
- Read accept: rd_en && !empty && !flush && !replay.
  - One-cycle latency: on the next edge, rd_data = RAM[rd_ptr] and rd_valid = 1, and rd_ptr increments.
  - In every cycle with no read accept: rd_valid = 0 and rd_data = 0.
- Read while empty: ignored; rd_valid = 0.
- replay: rd_ptr <= base_ptr. Any rd_en in the same cycle is ignored. A write in the same cycle is still accepted.
- commit: base_ptr <= rd_ptr, using the pre-edge value.
  - A read in the same cycle is accepted; that word stays uncommitted.
  - full and almost_full are evaluated from pre-edge pointers, so freed space is visible one cycle later.
- Priority: flush > replay > commit.
  - replay and commit in the same cycle: replay wins; commit is ignored.
  - flush: all pointers = 0, rd_valid = 0 on the next edge. wr_en and rd_en are ignored that cycle.
- Flags and occupancy are combinational from the registered pointers.
- No bypass path: a word written at edge N can first be accepted for read in cycle N+1, and appears on rd_data at edge N+2.

Optional Feature:
- Macro: CMD_FIFO_ERR_EN.
- Defined:
  - Adds output port err_ovf (1 bit), set sticky on a write attempt while full.
  - Adds output port err_udf (1 bit), set sticky on a read attempt while empty, with no flush and no replay that cycle.
  - Both flags are cleared only by reset or flush.
- Undefined: the two ports and their logic are absent. Overflow and underflow are silently ignored as described above.

Test Plan (DATA_W=64, DEPTH=8, AFULL_TH=2):
- Fill and drain: write 0x10..0x17 in consecutive cycles -> full=1 after the 8th, almost_full=1 from occupancy 6; read 8 words -> rd_data 0x10..0x17 with rd_valid, one cycle after each rd_en; empty=1 but occupancy stays 8 and full stays 1 until commit.
- Replay: write A0..A3, read 3 (A0,A1,A2), pulse replay, read 4 -> A0,A1,A2,A3; occupancy=4 throughout.
- Commit reclaim: with 8 resident entries and all read, pulse commit -> occupancy=0 and full=0 on the next cycle; then write 8 more across pointer wrap -> read order preserved, wrap bit toggles.
- Simultaneous events: replay+commit in the same cycle -> base unchanged, rd_ptr=base; commit+rd_en -> base = pre-edge rd_ptr and the read word is returned; write while full -> dropped (err_ovf=1 with CMD_FIFO_ERR_EN).
- Flush and reset: flush with 5 entries and an rd_en in the same cycle -> empty=1, occupancy=0, rd_valid=0 next cycle; assert reset asynchronously between edges mid-burst -> outputs go to reset values immediately, first post-reset read returns the first post-reset write.

Source files
------------

// File: rtl/cmd_replay_fifo.sv
// Purpose     : command FIFO with a replay window; read words stay resident until committed.
// Latency     : 1 cycle from an accepted rd_en to rd_data/rd_valid; a word written at edge N is readable from cycle N+1.
// Backpressure: full/almost_full to the producer; space is reclaimed only by commit or flush, never by a read.
//
// Ports:
//   clk, reset           single clock, asynchronous active-high reset
//   wr_en, wr_data       producer write; dropped while full or during flush
//   full, almost_full    no free entry / free entries <= AFULL_TH
//   rd_en                consumer read request; ignored while empty, or during flush/replay
//   rd_data, rd_valid    registered read result; both zero in cycles without an accepted read
//   empty                no unread entry (rd_ptr == wr_ptr)
//   replay               rewind rd_ptr to base_ptr
//   commit               release consumed entries (base_ptr <= rd_ptr)
//   flush                discard everything
//   occupancy            resident entries, read-but-uncommitted ones included
//
// Optional: define CMD_FIFO_ERR_EN to add sticky err_ovf / err_udf outputs,
// cleared only by reset or flush.
module cmd_replay_fifo #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = 2,
    parameter int PTR_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    input  logic              replay,
    input  logic              commit,
    input  logic              flush,
    output logic [PTR_W-1:0]  occupancy
`ifdef CMD_FIFO_ERR_EN
    ,
    output logic              err_ovf,
    output logic              err_udf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_P   = PTR_W'(AFULL_TH);

    logic [DATA_W-1:0] mem [DEPTH];

    // The extra top bit on each pointer is the wrap bit, which lets
    // wr_ptr == base_ptr + DEPTH (full) be told apart from wr_ptr == base_ptr.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] base_ptr;
    logic [PTR_W-1:0] free_cnt;

    logic wr_acc;
    logic rd_acc;

    // Flags come straight from the registered pointers, so space released by
    // a commit only becomes visible to the producer the cycle after.
    assign occupancy   = wr_ptr - base_ptr;
    assign free_cnt    = DEPTH_P - occupancy;
    assign full        = (occupancy == DEPTH_P);
    assign almost_full = (free_cnt <= AFULL_P);
    assign empty       = (rd_ptr == wr_ptr);

    assign wr_acc = wr_en && !full && !flush;
    // replay owns rd_ptr in its cycle, so a read request alongside it is dropped.
    assign rd_acc = rd_en && !empty && !flush && !replay;

    // Storage has no reset: contents are only ever observed through the
    // pointers, which are reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            base_ptr <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            base_ptr <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (replay) begin
                // A commit in the same cycle is ignored; base_ptr stays put.
                rd_ptr <= base_ptr;
            end else begin
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                // Pre-edge rd_ptr: a word read in this same cycle stays uncommitted.
                if (commit) begin
                    base_ptr <= rd_ptr;
                end
            end

            rd_valid <= rd_acc;
            rd_data  <= rd_acc ? mem[rd_ptr[AW-1:0]] : '0;
        end
    end

`ifdef CMD_FIFO_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else if (flush) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (wr_en && full) begin
                err_ovf <= 1'b1;
            end
            if (rd_en && empty && !replay) begin
                err_udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmd_replay_fifo.sv
module tb_cmd_replay_fifo;

    localparam int DATA_W   = 64;
    localparam int DEPTH    = 8;
    localparam int AFULL_TH = 2;
    localparam int PTR_W    = 4;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              almost_full;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              replay;
    logic              commit;
    logic              flush;
    logic [PTR_W-1:0]  occupancy;
`ifdef CMD_FIFO_ERR_EN
    logic              err_ovf;
    logic              err_udf;
`endif

    cmd_replay_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .replay      (replay),
        .commit      (commit),
        .flush       (flush),
        .occupancy   (occupancy)
`ifdef CMD_FIFO_ERR_EN
        ,
        .err_ovf     (err_ovf),
        .err_udf     (err_udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              wr;
        logic [DATA_W-1:0] wd;
        logic              rd;
        logic              rp;
        logic              cm;
        logic              fl;
        logic              full;
        logic              af;
        logic              empty;
        logic [PTR_W-1:0]  occ;
        logic              rv;
        logic [DATA_W-1:0] rdd;
        logic              ovf;
        logic              udf;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(
        input logic wr, input logic [DATA_W-1:0] wd, input logic rd,
        input logic rp, input logic cm, input logic fl,
        input logic e_full, input logic e_af, input logic e_empty,
        input int e_occ, input logic e_rv, input logic [DATA_W-1:0] e_rdd,
        input logic e_ovf, input logic e_udf);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.rp = rp; v.cm = cm; v.fl = fl;
        v.full = e_full; v.af = e_af; v.empty = e_empty;
        v.occ = PTR_W'(e_occ); v.rv = e_rv; v.rdd = e_rdd;
        v.ovf = e_ovf; v.udf = e_udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input vec_t v);
        chk({tag, " full"},        DATA_W'(full),        DATA_W'(v.full));
        chk({tag, " almost_full"}, DATA_W'(almost_full), DATA_W'(v.af));
        chk({tag, " empty"},       DATA_W'(empty),       DATA_W'(v.empty));
        chk({tag, " occupancy"},   DATA_W'(occupancy),   DATA_W'(v.occ));
        chk({tag, " rd_valid"},    DATA_W'(rd_valid),    DATA_W'(v.rv));
        chk({tag, " rd_data"},     rd_data,              v.rdd);
`ifdef CMD_FIFO_ERR_EN
        chk({tag, " err_ovf"},     DATA_W'(err_ovf),     DATA_W'(v.ovf));
        chk({tag, " err_udf"},     DATA_W'(err_udf),     DATA_W'(v.udf));
`endif
    endtask

    // Drive one cycle of inputs, let one edge pass, then compare post-edge outputs.
    task automatic apply(input string tag, input vec_t v);
        wr_en = v.wr; wr_data = v.wd; rd_en = v.rd;
        replay = v.rp; commit = v.cm; flush = v.fl;
        @(posedge clk);
        #1;
        chk_outputs(tag, v);
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        replay = 1'b0; commit = 1'b0; flush = 1'b0;
    endtask

    initial begin
        vec_t rst_v;
        logic o;
        logic u;

        idle_inputs();
        reset = 1'b1;
        #2;
        rst_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk_outputs("reset", rst_v);
        #10;
        reset = 1'b0;   // released at t=12, between edges

        o = 1'b0;
        u = 1'b0;
        // Fill 0x10..0x17; almost_full from occupancy 6, full at 8.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 64'h10 + i, 0, 0, 0, 0, i == 7, i >= 5, 0, i + 1, 0, 0, o, u));
        o = 1'b1;   // write while full: dropped
        vecs.push_back(mk(1, 64'h99, 0, 0, 0, 0, 1, 1, 0, 8, 0, 0, o, u));
        // Drain: reads do not reclaim space.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, i == 7, 8, 1, 64'h10 + i, o, u));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 8, 0, 0, o, u));
        u = 1'b1;   // read while empty: ignored
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 8, 0, 0, o, u));
        // Commit everything; pointers now sit at 8 (wrap bit set).
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, o, u));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 64'hA0 + i, 0, 0, 0, 0, 0, 0, 0, i + 1, 0, 0, o, u));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 1, 64'hA0 + i, o, u));
        // replay with rd_en: the read is dropped.
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 4, 0, 0, o, u));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, i == 3, 4, 1, 64'hA0 + i, o, u));
        // replay+commit: replay wins, base unchanged.
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 4, 0, 0, o, u));
        // commit+read: base takes the pre-edge rd_ptr, word returned.
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 4, 1, 64'hA0, o, u));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 3, 1, 64'hA1, o, u));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, o, u));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 64'hC0 + i, 0, 0, 0, 0, 0, 0, 0, i + 3, 0, 0, o, u));
        // Flush with 5 resident, plus rd_en and wr_en: all ignored, errors cleared.
        o = 1'b0;
        u = 1'b0;
        vecs.push_back(mk(1, 64'hEE, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, o, u));
        vecs.push_back(mk(1, 64'hD0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, o, u));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 64'hD0, o, u));
        // Write and read together while empty: no bypass, the read is ignored.
        u = 1'b1;
        vecs.push_back(mk(1, 64'hE0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, o, u));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 64'hE0, o, u));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1, 64'hF0 + i, 0, 0, 0, 0, i == 5, i >= 3, 0, i + 3, 0, 0, o, u));
        // commit while full with a write: full is judged pre-edge, write dropped.
        o = 1'b1;
        vecs.push_back(mk(1, 64'h77, 0, 0, 1, 0, 0, 1, 0, 6, 0, 0, o, u));
        vecs.push_back(mk(1, 64'h78, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, o, u));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 7, 1, 64'hF0, o, u));

        @(negedge clk);
        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges, mid-burst.
        apply("pre_rst", mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 7, 1, 64'hF1, o, u));
        #3;
        reset = 1'b1;
        #1;
        chk_outputs("async_rst", rst_v);
        idle_inputs();
        @(negedge clk);
        chk_outputs("rst_held", rst_v);
        reset = 1'b0;
        #1;
        apply("post_wr", mk(1, 64'h55, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        apply("post_rd", mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 64'h55, 0, 0));
        apply("post_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
